// File: rtl/src_fetch.sv
// rtl/src_fetch.sv - operand fetch from PC, register file, data memory or immediate
module src_fetch #(
    parameter int WIDTH   = 32,
    parameter int RADDR   = 5,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] imm,
    output logic             reg_re,
    output logic [RADDR-1:0] reg_addr,
    input  logic [WIDTH-1:0] reg_din,
    output logic             mem_req,
    output logic [WIDTH-1:0] mem_addr,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_din,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             err,
    output logic             busy
);

    // Counter only has to reach TIMEOUT-1, so it never wraps.
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [1:0] SEL_PC  = 2'b00;
    localparam logic [1:0] SEL_REG = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;
    localparam logic [1:0] SEL_IMM = 2'b11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REG_WAIT = 2'd1,
        MEM_WAIT = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t           state_q;
    logic             reg_re_q;
    logic [RADDR-1:0] reg_addr_q;
    logic             mem_req_q;
    logic [WIDTH-1:0] mem_addr_q;
    logic [WIDTH-1:0] dout_q;
    logic             dout_valid_q;
    logic             err_q;
    logic [CW-1:0]    cnt_q;

    // Fetch sequencer: every output is a register updated only here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            reg_re_q     <= 1'b0;
            reg_addr_q   <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        case (sel)
                            SEL_PC: begin
                                dout_q       <= pc;
                                err_q        <= 1'b0;
                                dout_valid_q <= 1'b1;
                                state_q      <= DONE;
                            end
                            SEL_IMM: begin
                                dout_q       <= imm;
                                err_q        <= 1'b0;
                                dout_valid_q <= 1'b1;
                                state_q      <= DONE;
                            end
                            SEL_REG: begin
                                reg_re_q   <= 1'b1;
                                reg_addr_q <= addr[RADDR-1:0];
                                state_q    <= REG_WAIT;
                            end
                            default: begin
                                mem_req_q  <= 1'b1;
                                mem_addr_q <= addr;
                                cnt_q      <= '0;
                                state_q    <= MEM_WAIT;
                            end
                        endcase
                    end
                end
                REG_WAIT: begin
                    reg_re_q     <= 1'b0;
                    dout_q       <= reg_din;
                    err_q        <= 1'b0;
                    dout_valid_q <= 1'b1;
                    state_q      <= DONE;
                end
                MEM_WAIT: begin
                    // A late ack on the final counted cycle still wins over the timeout.
                    if (mem_ack) begin
                        mem_req_q    <= 1'b0;
                        dout_q       <= mem_din;
                        err_q        <= 1'b0;
                        dout_valid_q <= 1'b1;
                        state_q      <= DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        mem_req_q    <= 1'b0;
                        dout_q       <= '0;
                        err_q        <= 1'b1;
                        dout_valid_q <= 1'b1;
                        state_q      <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    if (dout_ready) begin
                        dout_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
            endcase
        end
    end

    assign reg_re     = reg_re_q;
    assign reg_addr   = reg_addr_q;
    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign err        = err_q;
    assign busy       = (state_q != IDLE);

endmodule
